// File: rtl/reed_conditioner.sv
// ============================================================================
//  Module   : reed_conditioner
//  Purpose  : Synchronises and debounces the reed wheel sensor, enforces a
//             minimum revolution spacing, emits one pulse per accepted
//             revolution and measures the revolution period.
//             Define REED_GLITCH_COUNT_EN to add the glitch_count output.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module reed_conditioner #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int LOCKOUT_CYCLES  = 64,
    parameter int STALL_CYCLES    = 4000,
    parameter int PERIOD_WIDTH    = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    reed,
    output logic                    reed_level,
    output logic                    reed_pulse,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    stalled
`ifdef REED_GLITCH_COUNT_EN
    ,
    output logic [7:0]              glitch_count
`endif
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0]      c_deb_last = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PERIOD_WIDTH:0] c_lockout  = (PERIOD_WIDTH + 1)'(LOCKOUT_CYCLES);
    localparam logic [PERIOD_WIDTH:0] c_stall    = (PERIOD_WIDTH + 1)'(STALL_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic                    r_sync1;
    logic                    r_sync2;
    logic [DEB_W-1:0]        r_deb_cnt;
    logic                    r_level_prev;
    logic [PERIOD_WIDTH-1:0] r_elapsed;
    state_t                  r_state;

    logic                    w_candidate;
    logic [PERIOD_WIDTH:0]   w_elapsed_inc;
    logic                    w_accept;
    logic                    w_reject;
    logic                    w_stall_hit;

    // One extra bit so elapsed+1 never wraps when compared to the thresholds
    assign w_elapsed_inc = {1'b0, r_elapsed} + (PERIOD_WIDTH + 1)'(1);
    assign w_candidate   = reed_level & ~r_level_prev;
    assign w_accept      = w_candidate & ((r_state == ST_IDLE) | (w_elapsed_inc >= c_lockout));
    assign w_reject      = w_candidate & (r_state == ST_RUN) & (w_elapsed_inc < c_lockout);
    assign w_stall_hit   = (r_state == ST_RUN) & ~w_accept & (w_elapsed_inc == c_stall);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= reed;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_deb_cnt    <= '0;
            reed_level   <= 1'b0;
            r_level_prev <= 1'b0;
        end else begin
            r_level_prev <= reed_level;
            if (r_sync2 == reed_level) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_deb_last) begin
                reed_level <= r_sync2;
                r_deb_cnt  <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_elapsed    <= '0;
            reed_pulse   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b1;
        end else begin
            reed_pulse <= w_accept;
            if (w_accept) begin
                r_elapsed <= '0;
            end else if (r_elapsed != '1) begin
                r_elapsed <= r_elapsed + PERIOD_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        stalled <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        period       <= w_elapsed_inc[PERIOD_WIDTH-1:0];
                        period_valid <= 1'b1;
                    end else if (w_stall_hit) begin
                        stalled      <= 1'b1;
                        period_valid <= 1'b0;
                        period       <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef REED_GLITCH_COUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            glitch_count <= '0;
        end else if (w_reject && (glitch_count != 8'hFF)) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end
`else
    logic w_unused_reject;
    assign w_unused_reject = w_reject;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reed_conditioner.sv
// ============================================================================
//  Module   : tb_reed_conditioner
//  Purpose  : Directed and randomized checks of reed_conditioner against a
//             timestamp-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_reed_conditioner;

    localparam int DEB   = 8;
    localparam int LOCK  = 64;
    localparam int STALL = 4000;
    localparam int PW    = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          reed  = 1'b0;
    logic          reed_level;
    logic          reed_pulse;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          stalled;
`ifdef REED_GLITCH_COUNT_EN
    logic [7:0]    glitch_count;
`endif

    reed_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LOCKOUT_CYCLES  (LOCK),
        .STALL_CYCLES    (STALL),
        .PERIOD_WIDTH    (PW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .reed         (reed),
        .reed_level   (reed_level),
        .reed_pulse   (reed_pulse),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled)
`ifdef REED_GLITCH_COUNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: reed samples, a debounce window and timestamps of acceptance
    int edge_cnt = 0;
    int last_acc = 0;
    bit rq[$];
    bit sw[$];
    bit m_level, m_rose, m_pulse, m_valid, m_stalled, m_run;
    int m_period, m_glitch;
    int pulse_cnt = 0;
    int last_pulse_edge = 0;

    task automatic model_reset();
        rq = '{1'b0, 1'b0};
        sw.delete();
        m_level = 0; m_rose = 0; m_pulse = 0; m_valid = 0;
        m_stalled = 1; m_run = 0; m_period = 0; m_glitch = 0;
    endtask

    task automatic model_step();
        bit sync_now;
        bit cand;
        bit all_diff;
        int since;
        if (!reset) begin
            model_reset();
            return;
        end
        sync_now = rq[rq.size()-2];
        rq.push_back(reed);
        if (rq.size() > 4) void'(rq.pop_front());
        cand    = m_rose;
        since   = edge_cnt - last_acc;
        m_pulse = 0;
        if (cand && (!m_run || since >= LOCK)) begin
            m_pulse = 1;
            if (m_run) begin
                m_period = since;
                m_valid  = 1;
            end
            m_run     = 1;
            m_stalled = 0;
            last_acc  = edge_cnt;
        end else begin
            if (cand && m_glitch < 255) m_glitch++;
            if (m_run && since == STALL) begin
                m_stalled = 1; m_valid = 0; m_period = 0; m_run = 0;
            end
        end
        // Level flips once DEB consecutive synchronised samples disagree with it
        sw.push_back(sync_now);
        if (sw.size() > DEB) void'(sw.pop_front());
        m_rose = 0;
        if (sw.size() == DEB) begin
            all_diff = 1;
            foreach (sw[i]) if (sw[i] == m_level) all_diff = 0;
            if (all_diff) begin
                m_level = ~m_level;
                m_rose  = m_level;
                sw.delete();
            end
        end
    endtask

    initial model_reset();

    always @(posedge clock) begin
        edge_cnt++;
        model_step();
        #1;
        check("reed_level",   reed_level,   m_level);
        check("reed_pulse",   reed_pulse,   m_pulse);
        check("period",       period,       m_period);
        check("period_valid", period_valid, m_valid);
        check("stalled",      stalled,      m_stalled);
`ifdef REED_GLITCH_COUNT_EN
        check("glitch_count", glitch_count, m_glitch);
`endif
        if (reed_pulse) begin
            pulse_cnt++;
            last_pulse_edge = edge_cnt;
        end
    end

    task automatic drive(input bit v, input int n);
        reed = v;
        repeat (n) @(negedge clock);
    endtask

    int base;
    int rel;
    int dur;

    initial begin
        #1 reset = 1'b0;
        reed = 1'b1;
        repeat (3) @(negedge clock);

        // Reset with reed high, then release
        check("t1_stalled_reset", stalled, 1);
        check("t1_level_reset", reed_level, 0);
        base = pulse_cnt;
        reset = 1'b1;
        rel = edge_cnt;
        drive(1, 20);
        check("t1_pulse_count", pulse_cnt - base, 1);
        check("t1_pulse_edge", last_pulse_edge - rel, 11);
        check("t1_stalled", stalled, 0);
        check("t1_valid", period_valid, 0);

        // Clean edges 500 cycles apart
        drive(0, 100);
        for (int k = 0; k < 3; k++) begin
            drive(1, 250);
            if (k >= 1) begin
                check("t2_period", period, 500);
                check("t2_valid", period_valid, 1);
                check("t2_stalled", stalled, 0);
            end
            drive(0, 250);
        end

        // Bounce, then settle high
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) drive(bit'(i % 2 == 0), 3);
        drive(1, 50);
        check("t3_pulse_count", pulse_cnt - base, 1);
        check("t3_level", reed_level, 1);

        // Lockout rejection at 40, acceptance at 200
        drive(0, 100);
        drive(1, 15);
        drive(0, 25);
        check("t4_first_period", period, 150);
        base = pulse_cnt;
        drive(1, 15);
        drive(0, 145);
        check("t4_rejected", pulse_cnt - base, 0);
        check("t4_period_kept", period, 150);
`ifdef REED_GLITCH_COUNT_EN
        check("t4_glitch", glitch_count, 1);
`endif
        drive(1, 50);
        check("t4_pulse_count", pulse_cnt - base, 1);
        check("t4_period", period, 200);

        // Stall, then recovery
        drive(0, 4100);
        check("t5_stalled", stalled, 1);
        check("t5_period", period, 0);
        check("t5_valid", period_valid, 0);
        base = pulse_cnt;
        drive(1, 50);
        check("t5_pulse", pulse_cnt - base, 1);
        check("t5_stalled_clr", stalled, 0);
        check("t5_valid_still0", period_valid, 0);
        drive(0, 100);
        drive(1, 50);
        check("t5_valid", period_valid, 1);
        check("t5_period2", period, 150);

        // Reset mid-debounce
        drive(0, 50);
        reed = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_level", reed_level, 0);
        check("t6_pulse", reed_pulse, 0);
        check("t6_period", period, 0);
        check("t6_valid", period_valid, 0);
        check("t6_stalled", stalled, 1);
        repeat (3) @(negedge clock);
        base = pulse_cnt;
        reset = 1'b1;
        rel = edge_cnt;
        drive(1, 20);
        check("t6_pulse_count", pulse_cnt - base, 1);
        check("t6_pulse_edge", last_pulse_edge - rel, 11);

        // Randomized segments, occasionally with a reset
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b0;
                drive(reed, $urandom_range(1, 3));
                reset = 1'b1;
            end else begin
                case ($urandom_range(0, 19))
                    0:               dur = $urandom_range(3000, 4500);
                    1, 2, 3, 4, 5:   dur = $urandom_range(20, 300);
                    default:         dur = $urandom_range(1, 12);
                endcase
                drive(bit'($urandom_range(0, 1)), dur);
            end
        end
        drive(0, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
